adc_sample_packer: RTL

- Parametrised multi-channel ADC capture packer in the rf_clk domain; sits between the RF data converter ADC streams and the rf_clk-to-ps_clk async FIFO.
- Requantises each channel's samples from IN_W to OUT_W bits, with selectable truncate or round-with-saturate.
- Buffers each channel, merges all channels into one sample-major interleaved beat, and frames a capture of cfg_beats beats with tlast.
- Detects per-channel overflow; an overflow aborts the capture cleanly.

---
 rtl/adc_sample_packer.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/adc_sample_packer.sv
// Multi-channel ADC capture packer (rf_clk domain).
// Each channel is requantised IN_W -> OUT_W, buffered in its own FIFO, then
// all channels are merged into one sample-major interleaved output beat.
// A capture is cfg_beats output beats long and ends with tlast; a FIFO
// overflow on any channel aborts the capture.
//
// Handshake: a beat moves across an AXI-Stream port on a rising edge where
// tvalid and tready are both high. Once m_axis_tvalid is high, m_axis_tdata
// and m_axis_tlast stay stable until that handshake (the one exception is
// tlast, which is forced high when the capture aborts). s_axis_tready is
// always high, so an input beat is "offered" whenever its tvalid is high and
// is either taken or silently discarded.
module adc_sample_packer #(
  parameter int NUM_CH     = 6,
  parameter int SPB        = 4,
  parameter int IN_W       = 16,
  parameter int OUT_W      = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic                          rf_clk,
  input  logic                          rf_rstb,
  input  logic [NUM_CH*SPB*IN_W-1:0]    s_axis_tdata,
  input  logic [NUM_CH-1:0]             s_axis_tvalid,
  output logic [NUM_CH-1:0]             s_axis_tready,
  output logic [NUM_CH*SPB*OUT_W-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  input  logic                          cfg_start,
  input  logic                          cfg_round,
  input  logic [CNT_W-1:0]              cfg_beats,
  output logic                          busy,
  output logic                          done,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [1:0]                    dbg_state
);

  localparam int SH = IN_W - OUT_W;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = SPB * OUT_W;
  localparam int OW = NUM_CH * CW;
  localparam int MAXI = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [IN_W:0] MAXV = MAXI[IN_W:0];
  localparam logic signed [IN_W:0] MINV = ~MAXV;
  localparam logic signed [IN_W:0] HALF = (IN_W + 1)'(1) << (SH - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2,
    S_ABORT   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beats_q;
  logic              round_q;
  logic [CNT_W-1:0]  in_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W-1:0]  drop_q;
  logic              ovf_q;
  logic [OW-1:0]     out_data_q;
  logic              out_valid_q;
  logic              out_last_q;

  logic [CW-1:0]     mem [NUM_CH][FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q [NUM_CH];
  logic [AW:0]       rd_ptr_q [NUM_CH];

  logic [CW-1:0]     q_word [NUM_CH];
  logic [OW-1:0]     merged;
  logic [NUM_CH-1:0] fifo_full, fifo_empty, push, drop;
  logic              any_drop, pop, out_hs, start_ok, flush;
  logic [CNT_W-1:0]  drop_nx;

  // Requantise one signed sample: arithmetic shift, optionally rounded
  // half-up and saturated (sum is formed one bit wider than the input).
  function automatic logic [OUT_W-1:0] requant(input logic [IN_W-1:0] smp,
                                               input logic rnd);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] shf;
    ext = signed'({smp[IN_W-1], smp});
    if (!rnd) begin
      shf = ext >>> SH;
      return shf[OUT_W-1:0];
    end
    shf = (ext + HALF) >>> SH;
    if (shf > MAXV) return MAXV[OUT_W-1:0];
    if (shf < MINV) return MINV[OUT_W-1:0];
    return shf[OUT_W-1:0];
  endfunction

  // Requantise every channel's input beat ahead of its FIFO write.
  always_comb begin
    q_word = '{default: '0};
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < SPB; s++) begin
        q_word[c][s*OUT_W +: OUT_W] =
          requant(s_axis_tdata[(c*SPB + s)*IN_W +: IN_W], round_q);
      end
    end
  end

  // Per-channel FIFO status, input acceptance and overflow detection.
  always_comb begin
    fifo_full  = '0;
    fifo_empty = '0;
    push       = '0;
    drop       = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      fifo_full[c]  = (wr_ptr_q[c] - rd_ptr_q[c]) == (AW + 1)'(FIFO_DEPTH);
      fifo_empty[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
      if (state_q == S_CAPTURE && s_axis_tvalid[c] && in_cnt_q[c] < beats_q) begin
        push[c] = !fifo_full[c];
        drop[c] = fifo_full[c];
      end
    end
  end

  assign any_drop = |drop;
  assign out_hs   = out_valid_q && m_axis_tready;
  assign start_ok = (state_q == S_IDLE) && cfg_start && (cfg_beats != '0);
  // Pop every FIFO together; never on the cycle an overflow aborts.
  assign pop      = (state_q == S_CAPTURE) && !any_drop && (&(~fifo_empty)) &&
                    (!out_valid_q || out_hs) && (out_cnt_q < beats_q);
  assign flush    = start_ok ||
                    (state_q == S_ABORT && (!out_valid_q || out_hs));

  // Sample-major interleave of the FIFO heads into one output word.
  always_comb begin
    merged = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < SPB; s++) begin
        merged[(s*NUM_CH + c)*OUT_W +: OUT_W] =
          mem[c][rd_ptr_q[c][AW-1:0]][s*OUT_W +: OUT_W];
      end
    end
  end

  // Saturating drop counter increment by the number of dropped beats.
  always_comb begin
    logic [CNT_W-1:0] n_drop;
    logic [CNT_W:0]   sum;
    n_drop = '0;
    for (int c = 0; c < NUM_CH; c++) n_drop = n_drop + CNT_W'(drop[c]);
    sum     = {1'b0, drop_q} + {1'b0, n_drop};
    drop_nx = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_ok) state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (any_drop)                  state_d = S_ABORT;
        else if (out_hs && out_last_q) state_d = S_DONE;
      end
      S_DONE:    state_d = S_IDLE;
      S_ABORT:   if (!out_valid_q || out_hs) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // FIFO storage (no reset needed; pointers define validity).
  always_ff @(posedge rf_clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr_q[c][AW-1:0]] <= q_word[c];
    end
  end

  // FIFO pointers and per-channel input beat counters.
  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        in_cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flush) begin
          wr_ptr_q[c] <= '0;
          rd_ptr_q[c] <= '0;
        end else begin
          if (push[c]) wr_ptr_q[c] <= wr_ptr_q[c] + 1'b1;
          if (pop)     rd_ptr_q[c] <= rd_ptr_q[c] + 1'b1;
        end
        if (start_ok)     in_cnt_q[c] <= '0;
        else if (push[c]) in_cnt_q[c] <= in_cnt_q[c] + 1'b1;
      end
    end
  end

  // Capture configuration, output counter, drop counter and overflow flag.
  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      beats_q   <= '0;
      round_q   <= 1'b0;
      out_cnt_q <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else if (start_ok) begin
      beats_q   <= cfg_beats;
      round_q   <= cfg_round;
      out_cnt_q <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      if (pop)      out_cnt_q <= out_cnt_q + 1'b1;
      if (any_drop) begin
        drop_q <= drop_nx;
        ovf_q  <= 1'b1;
      end
    end
  end

  // Registered output slice; loads a merged beat whenever it is free.
  always_ff @(posedge rf_clk or negedge rf_rstb) begin
    if (!rf_rstb) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else if (pop) begin
      out_data_q  <= merged;
      out_valid_q <= 1'b1;
      out_last_q  <= (out_cnt_q + 1'b1) == beats_q;
    end else if (out_hs || start_ok) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end
  end

  assign s_axis_tready = '1;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_valid_q && (out_last_q || state_q == S_ABORT);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign overflow      = ovf_q;
  assign drop_cnt      = drop_q;
  assign dbg_state     = state_q;

endmodule
